// File: rtl/gemm_tile_scheduler.sv
// GEMM tile sequencer: walks an MxK * KxN problem tile by tile (n, then m,
// then k), programs each tile into the gemm register block over the system bus,
// waits for queue space after each tile and finally waits for the done flag.
module gemm_tile_scheduler #(
    parameter int          BLK_M     = 16,
    parameter int          BLK_N     = 16,
    parameter int          BLK_K     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h9000_0000,
    parameter int          DIM_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_m,
    input  logic [DIM_W-1:0] cfg_k,
    input  logic [DIM_W-1:0] cfg_n,
    input  logic [31:0]      cfg_a_addr,
    input  logic [31:0]      cfg_b_addr,
    input  logic [31:0]      cfg_c_addr,
    output logic             busy,
    output logic             done,
    output logic             bus_en,
    output logic             bus_rdwr,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wr_data,
    input  logic [31:0]      bus_rd_data
);
    // one extra bit so that offset + block step can never wrap
    localparam int CW = DIM_W + 1;
    localparam logic [CW-1:0] BM = CW'(BLK_M);
    localparam logic [CW-1:0] BN = CW'(BLK_N);
    localparam logic [CW-1:0] BK = CW'(BLK_K);

    typedef enum logic [3:0] {
        IDLE, CALC, WR, FULL_REQ, FULL_CHK, NEXT, DONE_REQ, DONE_CHK, DONE
    } state_t;

    state_t            state, nstate;
    logic [2:0]        wr_idx, nwr_idx;
    logic [DIM_W-1:0]  dim_m, dim_k, dim_n;
    logic [31:0]       a_base, b_base, c_base;
    logic [CW-1:0]     m_c, k_c, n_c;
    logic [31:0]       at_r, bt_r, ct_r, dsz_r;
    logic [1:0]        ctl_r;

    logic [CW-1:0]     dm_x, dk_x, dn_x;
    logic [CW-1:0]     m_rem, k_rem, n_rem, msize, ksize, nsize;
    logic [CW-1:0]     k_step, m_step, n_step;
    logic [31:0]       a_t, b_t, c_t, dsz;
    logic              first, last, tiles_left, zero_dim;

    logic              n_busy, n_done, n_en, n_rdwr;
    logic [31:0]       n_addr, n_wdata;

    assign dm_x = {1'b0, dim_m};
    assign dk_x = {1'b0, dim_k};
    assign dn_x = {1'b0, dim_n};

    // current tile geometry and addresses, registered during CALC
    always_comb begin
        m_rem = dm_x - m_c;
        k_rem = dk_x - k_c;
        n_rem = dn_x - n_c;
        msize = (m_rem > BM) ? BM : m_rem;
        ksize = (k_rem > BK) ? BK : k_rem;
        nsize = (n_rem > BN) ? BN : n_rem;
        first = (k_c == '0);
        last  = ((k_c + BK) >= dk_x);
        a_t   = a_base + 32'(m_c) * 32'(dim_k) + 32'(k_c);
        // B points at the last row of the tile's k-slice
        b_t   = b_base + 32'(k_c + ksize - CW'(1)) * 32'(dim_n) + 32'(n_c);
        c_t   = c_base + 32'(m_c) * 32'(dim_n) + 32'(n_c);
        dsz   = 32'(msize) | (32'(ksize) << 5) | (32'(nsize) << 10);
    end

    assign k_step     = k_c + BK;
    assign m_step     = m_c + BM;
    assign n_step     = n_c + BN;
    assign tiles_left = (k_step < dk_x) || (m_step < dm_x) || (n_step < dn_x);
    assign zero_dim   = (cfg_m == '0) || (cfg_k == '0) || (cfg_n == '0);

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            wr_idx <= '0;
        end else begin
            state  <= nstate;
            wr_idx <= nwr_idx;
        end
    end

    // next state, plus the output values for that next state so outputs can be
    // registered yet line up with the state they belong to
    always_comb begin
        nstate  = state;
        nwr_idx = wr_idx;
        case (state)
            IDLE:     if (start) nstate = zero_dim ? DONE : CALC;
            CALC:     begin nstate = WR; nwr_idx = '0; end
            WR:       if (wr_idx == 3'd6) nstate = FULL_REQ;
                      else nwr_idx = wr_idx + 3'd1;
            FULL_REQ: nstate = FULL_CHK;
            FULL_CHK: if (bus_rd_data != 32'd1) nstate = NEXT;
            NEXT:     nstate = tiles_left ? CALC : DONE_REQ;
            DONE_REQ: nstate = DONE_CHK;
            DONE_CHK: if (bus_rd_data == 32'd1) nstate = DONE;
            DONE:     nstate = IDLE;
            default:  nstate = IDLE;
        endcase

        n_busy  = (nstate != IDLE) && (nstate != DONE);
        n_done  = (nstate == DONE);
        n_en    = 1'b0;
        n_rdwr  = 1'b0;
        n_addr  = '0;
        n_wdata = '0;
        case (nstate)
            WR: begin
                n_en   = 1'b1;
                n_rdwr = 1'b1;
                // DIM goes last: writing it enqueues the tile
                case (nwr_idx)
                    3'd0:    begin n_addr = BASE_ADDR + 32'd12; n_wdata = 32'(dim_k); end
                    3'd1:    begin n_addr = BASE_ADDR + 32'd16; n_wdata = 32'(dim_n); end
                    3'd2:    begin n_addr = BASE_ADDR;          n_wdata = at_r;       end
                    3'd3:    begin n_addr = BASE_ADDR + 32'd4;  n_wdata = bt_r;       end
                    3'd4:    begin n_addr = BASE_ADDR + 32'd8;  n_wdata = ct_r;       end
                    3'd5:    begin n_addr = BASE_ADDR + 32'd20; n_wdata = {30'd0, ctl_r}; end
                    default: begin n_addr = BASE_ADDR + 32'd24; n_wdata = dsz_r;      end
                endcase
            end
            FULL_REQ, FULL_CHK: begin
                n_en   = 1'b1;
                n_addr = BASE_ADDR;
            end
            DONE_REQ, DONE_CHK: begin
                n_en   = 1'b1;
                n_addr = BASE_ADDR + 32'd24;
            end
            default: ;
        endcase
    end

    // registered outputs, latched command, tile registers and tile counters
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            bus_en      <= 1'b0;
            bus_rdwr    <= 1'b0;
            bus_addr    <= '0;
            bus_wr_data <= '0;
            dim_m       <= '0;
            dim_k       <= '0;
            dim_n       <= '0;
            a_base      <= '0;
            b_base      <= '0;
            c_base      <= '0;
            m_c         <= '0;
            k_c         <= '0;
            n_c         <= '0;
            at_r        <= '0;
            bt_r        <= '0;
            ct_r        <= '0;
            dsz_r       <= '0;
            ctl_r       <= '0;
        end else begin
            busy        <= n_busy;
            done        <= n_done;
            bus_en      <= n_en;
            bus_rdwr    <= n_rdwr;
            bus_addr    <= n_addr;
            bus_wr_data <= n_wdata;
            if (state == IDLE && start) begin
                dim_m  <= cfg_m;
                dim_k  <= cfg_k;
                dim_n  <= cfg_n;
                a_base <= cfg_a_addr;
                b_base <= cfg_b_addr;
                c_base <= cfg_c_addr;
                m_c    <= '0;
                k_c    <= '0;
                n_c    <= '0;
            end
            if (state == CALC) begin
                at_r  <= a_t;
                bt_r  <= b_t;
                ct_r  <= c_t;
                dsz_r <= dsz;
                ctl_r <= {first, last};
            end
            if (state == NEXT) begin
                if (k_step < dk_x) begin
                    k_c <= k_step;
                end else begin
                    k_c <= '0;
                    if (m_step < dm_x) begin
                        m_c <= m_step;
                    end else begin
                        m_c <= '0;
                        n_c <= n_step;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Directed bench for gemm_tile_scheduler with a tiny bus slave model: queue-full
// flag on +0 (held for a programmable number of reads), done flag on +24.
module tb_gemm_tile_scheduler;
    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] cfg_m, cfg_k, cfg_n;
    logic [31:0] cfg_a_addr, cfg_b_addr, cfg_c_addr;
    logic        busy, done, bus_en, bus_rdwr;
    logic [31:0] bus_addr, bus_wr_data, bus_rd_data;

    always #5 clk = ~clk;

    gemm_tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_k(cfg_k), .cfg_n(cfg_n),
        .cfg_a_addr(cfg_a_addr), .cfg_b_addr(cfg_b_addr), .cfg_c_addr(cfg_c_addr),
        .busy(busy), .done(done), .bus_en(bus_en), .bus_rdwr(bus_rdwr),
        .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data)
    );

    int          n_cmp = 0, n_err = 0;
    logic [31:0] wadr[$], wdat[$];
    int          wcyc[$];
    int          cyc = 0, rd0 = 0, rd24 = 0, done_cnt = 0, en_cnt = 0, full_left = 0;
    logic [31:0] resp = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%h), want %0d (0x%h)", tag, obs, obs, exp, exp);
        end
    endtask

    // one clock: present last cycle's read response, then log this cycle's bus
    task automatic tick();
        @(posedge clk);
        #1;
        bus_rd_data = resp;
        resp = '0;
        cyc++;
        if (bus_en) begin
            en_cnt++;
            if (bus_rdwr) begin
                wadr.push_back(bus_addr);
                wdat.push_back(bus_wr_data);
                wcyc.push_back(cyc);
            end else if (bus_addr == BASE) begin
                rd0++;
                if (full_left > 0) begin
                    resp = 32'd1;
                    full_left--;
                end
            end else if (bus_addr == BASE + 32'd24) begin
                rd24++;
                resp = 32'd1;
            end
        end
        if (done) done_cnt++;
    endtask

    task automatic clr_log();
        wadr.delete(); wdat.delete(); wcyc.delete();
        rd0 = 0; rd24 = 0; done_cnt = 0; en_cnt = 0;
    endtask

    task automatic do_start(input logic [15:0] m, input logic [15:0] k, input logic [15:0] n,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        cfg_m = m; cfg_k = k; cfg_n = n;
        cfg_a_addr = a; cfg_b_addr = b; cfg_c_addr = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_done(input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("done_within_budget", 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] wd(input int i);
        return (i < wdat.size()) ? wdat[i] : 32'hDEAD_BEEF;
    endfunction

    logic [31:0] exp1_d[7] = '{32'd16, 32'd16, 32'd0, 32'd496, 32'd512, 32'd3, 32'd16912};
    logic [31:0] exp_off[7] = '{32'd12, 32'd16, 32'd0, 32'd4, 32'd8, 32'd20, 32'd24};

    initial begin
        rst = 1'b1; start = 1'b0; bus_rd_data = '0;
        cfg_m = '0; cfg_k = '0; cfg_n = '0;
        cfg_a_addr = '0; cfg_b_addr = '0; cfg_c_addr = '0;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_en", 32'(bus_en), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wr_data, 32'd0);
        rst = 1'b0;
        tick();

        // single 16x16x16 tile
        clr_log();
        do_start(16'd16, 16'd16, 16'd16, 32'd0, 32'd256, 32'd512);
        chk("t1_calc_busy", 32'(busy), 32'd1);
        chk("t1_calc_en", 32'(bus_en), 32'd0);
        run_done(200);
        chk("t1_nwr", 32'(wdat.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t1_wd%0d", i), wd(i), exp1_d[i]);
            chk($sformatf("t1_wa%0d", i), (i < wadr.size()) ? wadr[i] : 32'd0, BASE + exp_off[i]);
        end
        chk("t1_rd0", 32'(rd0), 32'd2);
        chk("t1_rd24", 32'(rd24), 32'd2);
        tick();
        chk("t1_done_once", 32'(done_cnt), 32'd1);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 20x20x20: 8 tiles in n, m, k order
        clr_log();
        do_start(16'd20, 16'd20, 16'd20, 32'd0, 32'd256, 32'd512);
        run_done(400);
        chk("t2_nwr", 32'(wdat.size()), 32'd56);
        chk("t2_k", wd(0), 32'd20);
        chk("t2_t1_a", wd(9), 32'd16);
        chk("t2_t1_b", wd(10), 32'd636);
        chk("t2_t1_ctl", wd(12), 32'd1);
        chk("t2_t1_dim", wd(13), 32'd16528);
        chk("t2_t2_a", wd(16), 32'd320);
        chk("t2_t2_c", wd(18), 32'd832);
        chk("t2_t2_ctl", wd(19), 32'd2);
        chk("t2_t2_dim", wd(20), 32'd16900);
        chk("t2_t4_b", wd(31), 32'd572);
        chk("t2_t4_c", wd(32), 32'd528);
        chk("t2_t7_a", wd(51), 32'd336);
        chk("t2_t7_b", wd(52), 32'd652);
        chk("t2_t7_c", wd(53), 32'd848);
        chk("t2_t7_ctl", wd(54), 32'd1);
        chk("t2_t7_dim", wd(55), 32'd4228);
        chk("t2_t7_dim_addr", (wadr.size() == 56) ? wadr[55] : 32'd0, BASE + 32'd24);
        tick();

        // queue full for 5 reads between tile 0 and tile 1
        clr_log();
        full_left = 5;
        do_start(16'd32, 16'd16, 16'd16, 32'd0, 32'd256, 32'd512);
        run_done(200);
        chk("t3_nwr", 32'(wdat.size()), 32'd14);
        chk("t3_rd0", 32'(rd0), 32'd9);
        chk("t3_gap", (wcyc.size() == 14) ? 32'(wcyc[7] - wcyc[6]) : 32'd0, 32'd10);
        chk("t3_t1_a", wd(9), 32'd256);
        chk("t3_t1_c", wd(11), 32'd768);
        tick();

        // zero dimension: immediate done, no bus traffic; back-to-back start ignored
        clr_log();
        do_start(16'd4, 16'd4, 16'd0, 32'd0, 32'd0, 32'd0);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        cfg_n = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_b2b_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        chk("t4_no_bus", 32'(en_cnt), 32'd0);
        chk("t4_done_once", 32'(done_cnt), 32'd1);

        // reset during the 4th write, then replay from tile 0
        clr_log();
        do_start(16'd16, 16'd16, 16'd16, 32'd0, 32'd256, 32'd512);
        for (int i = 0; i < 20 && wdat.size() < 4; i++) tick();
        chk("t5_reached_wr4", 32'(wdat.size()), 32'd4);
        rst = 1'b1;
        tick();
        chk("t5_rst_en", 32'(bus_en), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_addr", bus_addr, 32'd0);
        rst = 1'b0;
        clr_log();
        tick(); tick(); tick();
        chk("t5_no_done", 32'(done_cnt), 32'd0);
        chk("t5_quiet", 32'(en_cnt), 32'd0);
        do_start(16'd16, 16'd16, 16'd16, 32'd0, 32'd256, 32'd512);
        run_done(200);
        chk("t5_nwr", 32'(wdat.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk($sformatf("t5_wd%0d", i), wd(i), exp1_d[i]);
        tick();

        // start while busy must not disturb the running job
        clr_log();
        do_start(16'd20, 16'd20, 16'd20, 32'd0, 32'd256, 32'd512);
        tick(); tick();
        cfg_m = 16'd1; cfg_k = 16'd1; cfg_n = 16'd1;
        cfg_a_addr = 32'h1234; cfg_b_addr = 32'h5678; cfg_c_addr = 32'h9ABC;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_done(400);
        chk("t6_nwr", 32'(wdat.size()), 32'd56);
        chk("t6_t1_b", wd(10), 32'd636);
        chk("t6_t4_c", wd(32), 32'd528);
        chk("t6_t7_dim", wd(55), 32'd4228);
        tick();
        chk("t6_done_once", 32'(done_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
